// File: rtl/rf_op_sequencer.sv
// Register-file operation sequencer: reads two source registers, runs a small ALU,
// and writes the result back with one cycle of address/data setup before the write strobe.
module rf_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_src1,
    input  logic [ADDR_W-1:0] req_src2,
    input  logic [ADDR_W-1:0] req_dst,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              rf_mode,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_value,
    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_value1,
    input  logic [DATA_W-1:0] rf_read_value2
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        SETUP,
        WRITE,
        DONE
    } stateT;

    stateT state;
    stateT nextState;

    logic [1:0]        opReg;
    logic [ADDR_W-1:0] dstReg;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic              aluCarry;
    logic              accept;

    // MSB of the returned value is the ADD carry-out or the SUB borrow.
    function automatic logic [DATA_W:0] aluOp(input logic [1:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        case (op)
            2'b00: r = {1'b0, a} + {1'b0, b};
            2'b01: r = {1'b0, a} - {1'b0, b};
            2'b10: r = {1'b0, a & b};
            2'b11: r = {1'b0, a};
        endcase
        return r;
    endfunction

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (req_valid) nextState = READ;
            READ:    nextState = EXEC;
            EXEC:    nextState = SETUP;
            SETUP:   nextState = WRITE;
            WRITE:   nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Operand/request capture: plain data, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            opReg  <= req_op;
            dstReg <= req_dst;
        end
        if (state == READ) begin
            opA <= rf_read_value1;
            opB <= rf_read_value2;
        end
    end

    // Visible outputs: cleared asynchronously so rf_mode drops the moment reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done           <= 1'b0;
            result         <= '0;
            carry          <= 1'b0;
            aluCarry       <= 1'b0;
            rf_mode        <= 1'b0;
            rf_write_addr  <= '0;
            rf_write_value <= '0;
            rf_read_addr1  <= '0;
            rf_read_addr2  <= '0;
        end else begin
            rf_mode <= (state == SETUP);
            done    <= (state == WRITE);
            if (accept) begin
                rf_read_addr1 <= req_src1;
                rf_read_addr2 <= req_src2;
            end
            // EXEC -> SETUP: result and address settle a full cycle before the strobe
            if (state == EXEC) begin
                {aluCarry, rf_write_value} <= aluOp(opReg, opA, opB);
                rf_write_addr              <= dstReg;
            end
            if (state == WRITE) begin
                result <= rf_write_value;
                carry  <= aluCarry;
            end
        end
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer: a behavioural register file plus a reference model of
// the register contents, driven by directed and randomized operations.
module tb_rf_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_src1;
    logic [4:0]  req_src2;
    logic [4:0]  req_dst;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        rf_mode;
    logic [4:0]  rf_write_addr;
    logic [15:0] rf_write_value;
    logic [4:0]  rf_read_addr1;
    logic [4:0]  rf_read_addr2;
    logic [15:0] rf_read_value1;
    logic [15:0] rf_read_value2;

    logic [15:0] rf [32];
    logic [15:0] refRf [32];
    logic        preloadEn;
    logic [4:0]  preloadAddr;
    logic [15:0] preloadVal;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acceptCnt = 0;
    int lastAcc = 0;
    int prevAcc = 0;

    rf_op_sequencer #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_src1(req_src1),
        .req_src2(req_src2),
        .req_dst(req_dst),
        .done(done),
        .result(result),
        .carry(carry),
        .rf_mode(rf_mode),
        .rf_write_addr(rf_write_addr),
        .rf_write_value(rf_write_value),
        .rf_read_addr1(rf_read_addr1),
        .rf_read_addr2(rf_read_addr2),
        .rf_read_value1(rf_read_value1),
        .rf_read_value2(rf_read_value2)
    );

    always #5 clk = ~clk;

    assign rf_read_value1 = rf[rf_read_addr1];
    assign rf_read_value2 = rf[rf_read_addr2];

    always @(posedge clk) begin
        if (preloadEn) rf[preloadAddr] <= preloadVal;
        else if (rf_mode) rf[rf_write_addr] <= rf_write_value;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) begin
            acceptCnt <= acceptCnt + 1;
            prevAcc   <= lastAcc;
            lastAcc   <= cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference ALU: {carry, result} from the arithmetic rules.
    function automatic logic [16:0] refAlu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] res;
        logic        c;
        case (op)
            2'd0: begin res = a + b; c = (int'(a) + int'(b)) > 65535; end
            2'd1: begin res = a - b; c = (a < b); end
            2'd2: begin res = a & b; c = 1'b0; end
            default: begin res = a; c = 1'b0; end
        endcase
        return {c, res};
    endfunction

    task automatic preload(input logic [4:0] a, input logic [15:0] v);
        @(negedge clk);
        preloadEn = 1'b1; preloadAddr = a; preloadVal = v;
        @(negedge clk);
        preloadEn = 1'b0;
        refRf[a] = v;
    endtask

    task automatic scramble();
        req_op   = 2'($urandom);
        req_src1 = 5'($urandom);
        req_src2 = 5'($urandom);
        req_dst  = 5'($urandom);
    endtask

    task automatic doOp(input logic [1:0] op, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input bit noise);
        logic [16:0] exp;
        int n0;
        exp = refAlu(op, refRf[s1], refRf[s2]);
        @(negedge clk);
        checkVal("readyIdle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2; req_dst = d;
        n0 = acceptCnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble();
        checkVal("accept", 32'(acceptCnt), 32'(n0 + 1));
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 5) begin
                checkVal("rfMode", 32'(rf_mode), 32'(k == 4));
                checkVal("donePulse", 32'(done), 32'(k == 5));
            end
            if (k == 1) begin
                checkVal("rdAddr1", 32'(rf_read_addr1), 32'(s1));
                checkVal("rdAddr2", 32'(rf_read_addr2), 32'(s2));
            end
            if (k == 4) begin
                checkVal("wrAddr", 32'(rf_write_addr), 32'(d));
                checkVal("wrValue", 32'(rf_write_value), 32'(exp[15:0]));
            end
            if (k == 5) begin
                checkVal("result", 32'(result), 32'(exp[15:0]));
                checkVal("carry", 32'(carry), 32'(exp[16]));
            end
            if (k == 6) begin
                checkVal("readyBack", 32'(req_ready), 32'd1);
                checkVal("noBusyAccept", 32'(acceptCnt), 32'(n0 + 1));
                checkVal("rfContent", 32'(rf[d]), 32'(exp[15:0]));
                checkVal("wrAddrHold", 32'(rf_write_addr), 32'(d));
            end
            if (noise && k <= 4) begin
                req_valid = 1'($urandom);
                scramble();
            end
            if (k == 5) req_valid = 1'b0;
        end
        refRf[d] = exp[15:0];
    endtask

    // Two requests with req_valid held high; the second reads the first's destination.
    task automatic backToBack(input logic [1:0] op1, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d1, input logic [1:0] op2, input logic [4:0] s2b,
                              input logic [4:0] d2);
        logic [16:0] exp1, exp2;
        int n0, dones;
        exp1 = refAlu(op1, refRf[s1], refRf[s2]);
        refRf[d1] = exp1[15:0];
        exp2 = refAlu(op2, refRf[d1], refRf[s2b]);
        refRf[d2] = exp2[15:0];
        @(negedge clk);
        n0 = acceptCnt;
        req_valid = 1'b1; req_op = op1; req_src1 = s1; req_src2 = s2; req_dst = d1;
        dones = 0;
        for (int c = 0; c < 30 && dones < 2; c++) begin
            @(negedge clk);
            if (acceptCnt == n0 + 1) begin
                req_op = op2; req_src1 = d1; req_src2 = s2b; req_dst = d2;
            end
            if (acceptCnt >= n0 + 2) req_valid = 1'b0;
            if (done) begin
                dones++;
                checkVal("b2bRes", 32'({carry, result}), 32'((dones == 1) ? exp1 : exp2));
            end
        end
        req_valid = 1'b0;
        checkVal("b2bDones", 32'(dones), 32'd2);
        checkVal("b2bSpacing", 32'(lastAcc - prevAcc), 32'd6);
        checkVal("b2bRf2", 32'(rf[d2]), 32'(exp2[15:0]));
    endtask

    task automatic abortOp(input logic [1:0] op, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d, input int atK);
        int dc;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2; req_dst = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= atK; k++) @(negedge clk);
        checkVal("preAbortMode", 32'(rf_mode), 32'(atK == 4));
        reset = 1'b1;
        #1;
        checkVal("abortMode", 32'(rf_mode), 32'd0);
        checkVal("abortDone", 32'(done), 32'd0);
        checkVal("abortReady", 32'(req_ready), 32'd0);
        checkVal("abortResult", 32'({carry, result}), 32'd0);
        checkVal("abortWr", 32'({rf_write_addr, rf_write_value}), 32'd0);
        checkVal("abortRd", 32'({rf_read_addr1, rf_read_addr2}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("readyAfterAbort", 32'(req_ready), 32'd1);
        dc = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || rf_mode) dc++;
        end
        checkVal("noDoneAfterAbort", 32'(dc), 32'd0);
        // Target contents are undefined after an interrupted write; re-establish a known value.
        preload(d, 16'h0000);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_op = 2'd0; req_src1 = 5'd0; req_src2 = 5'd0; req_dst = 5'd0;
        preloadEn = 1'b0; preloadAddr = 5'd0; preloadVal = 16'd0;
        for (int i = 0; i < 32; i++) preload(5'(i), 16'($urandom));
        preload(5'd0, 16'h1232);
        preload(5'd1, 16'h1263);
        preload(5'd2, 16'hA06B);
        preload(5'd4, 16'hFFFF);
        preload(5'd5, 16'h0001);

        @(negedge clk);
        checkVal("rstMode", 32'(rf_mode), 32'd0);
        checkVal("rstDone", 32'(done), 32'd0);
        checkVal("rstReady", 32'(req_ready), 32'd0);
        checkVal("rstResult", 32'({carry, result}), 32'd0);
        checkVal("rstWr", 32'({rf_write_addr, rf_write_value}), 32'd0);
        checkVal("rstRd", 32'({rf_read_addr1, rf_read_addr2}), 32'd0);
        reset = 1'b0;
        #1;
        checkVal("readyAfterRst", 32'(req_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkVal("idleMode", 32'(rf_mode), 32'd0);
        end

        doOp(2'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        checkVal("r3Literal", 32'(rf[3]), 32'h0000B2CE);
        doOp(2'd0, 5'd4, 5'd5, 5'd4, 1'b0);
        doOp(2'd1, 5'd5, 5'd4, 5'd6, 1'b0);
        doOp(2'd1, 5'd5, 5'd2, 5'd8, 1'b1);
        doOp(2'd2, 5'd1, 5'd2, 5'd9, 1'b1);
        doOp(2'd3, 5'd0, 5'($urandom), 5'd7, 1'b1);
        checkVal("r7Literal", 32'(rf[7]), 32'h00001232);

        backToBack(2'd0, 5'd1, 5'd2, 5'd10, 2'd1, 5'd5, 5'd11);

        abortOp(2'd0, 5'd1, 5'd2, 5'd12, 2);
        doOp(2'd0, 5'd1, 5'd2, 5'd12, 1'b0);
        abortOp(2'd1, 5'd3, 5'd4, 5'd13, 4);
        doOp(2'd1, 5'd3, 5'd4, 5'd13, 1'b0);

        repeat (40) begin
            doOp(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
